// File: rtl/barrel_pkg.sv
// Shared opcode type and helpers for the pipelined barrel shifter.
// Stage payload widths depend on WIDTH, so each module declares its payload struct locally.
package barrel_pkg;

    typedef enum logic [2:0] {
        OP_LSR = 3'b000,
        OP_LSL = 3'b001,
        OP_ROR = 3'b010,
        OP_ASR = 3'b011,
        OP_ROL = 3'b100,
        OP_RRX = 3'b101
    } shift_op_t;

    function automatic logic op_uses_amt(input shift_op_t op);
        return op inside {OP_LSR, OP_LSL, OP_ROR, OP_ASR, OP_ROL};
    endfunction

endpackage

// File: rtl/barrel_stage.sv
// One log-shifter slice (shift by 2^STAGE) plus its output register; 1 cycle latency.
// Holds its contents while i_rdy is low and reloads whenever it is empty or being drained.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STAGE   = 0,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_vld,
    input  logic               i_rdy,
    input  logic [WIDTH-1:0]   i_dat,
    input  logic [SHAMT_W-1:0] i_amt,
    input  shift_op_t          i_op,
    input  logic               i_carry,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_vld,
    output logic [WIDTH-1:0]   o_dat,
    output logic [SHAMT_W-1:0] o_amt,
    output shift_op_t          o_op,
    output logic               o_carry,
    output logic [TAG_W-1:0]   o_tag
);

    localparam int SH = 1 << STAGE;

    typedef struct packed {
        logic [WIDTH-1:0]   dat;
        logic [SHAMT_W-1:0] amt;
        shift_op_t          op;
        logic               carry;
        logic [TAG_W-1:0]   tag;
    } pay_t;

    pay_t             r_pay;
    logic             r_vld;
    logic             w_load;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_dat;
    logic             w_carry;

    assign w_ror  = (i_dat >> SH) | (i_dat << (WIDTH - SH));
    assign w_rol  = (i_dat << SH) | (i_dat >> (WIDTH - SH));
    assign w_load = i_vld && (!r_vld || i_rdy);

    // Carry follows the last bit shifted out, so an unset amount bit keeps the incoming carry.
    always_comb begin
        w_dat   = i_dat;
        w_carry = i_carry;
        if (i_op == OP_RRX) begin
            if (STAGE == 0) begin
                w_dat   = {i_carry, i_dat[WIDTH-1:1]};
                w_carry = i_dat[0];
            end
        end else if (op_uses_amt(i_op) && i_amt[STAGE]) begin
            case (i_op)
                OP_LSR: begin
                    w_dat   = i_dat >> SH;
                    w_carry = i_dat[SH-1];
                end
                OP_ASR: begin
                    w_dat   = $signed(i_dat) >>> SH;
                    w_carry = i_dat[SH-1];
                end
                OP_LSL: begin
                    w_dat   = i_dat << SH;
                    w_carry = i_dat[WIDTH-SH];
                end
                OP_ROR: begin
                    w_dat   = w_ror;
                    w_carry = w_ror[WIDTH-1];
                end
                OP_ROL: begin
                    w_dat   = w_rol;
                    w_carry = w_rol[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_pay <= '0;
        end else if (w_load) begin
            r_vld <= 1'b1;
            r_pay <= '{dat: w_dat, amt: i_amt, op: i_op, carry: w_carry, tag: i_tag};
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld   = r_vld;
    assign o_dat   = r_pay.dat;
    assign o_amt   = r_pay.amt;
    assign o_op    = r_pay.op;
    assign o_carry = r_pay.carry;
    assign o_tag   = r_pay.tag;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (LSR/LSL/ROR/ASR/ROL/RRX) with carry/zero/negative flags; latency SHAMT_W.
// Full valid/ready back-pressure: a blocked output stalls every full stage while empty stages still fill.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int TAG_W   = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [SHAMT_W-1:0] in_amt,
    input  logic [2:0]         in_op,
    input  logic               in_cin,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_res,
    output logic               out_cout,
    output logic               out_z,
    output logic               out_n,
    output logic [TAG_W-1:0]   out_tag
);

    logic [SHAMT_W:0]   w_vld;
    logic [SHAMT_W:0]   w_rdy;
    logic [WIDTH-1:0]   w_dat   [SHAMT_W+1];
    logic [SHAMT_W-1:0] w_amt   [SHAMT_W+1];
    shift_op_t          w_op    [SHAMT_W+1];
    logic               w_carry [SHAMT_W+1];
    logic [TAG_W-1:0]   w_tag   [SHAMT_W+1];
    logic               w_unused;

    assign w_vld[0]   = in_valid;
    assign w_dat[0]   = in_a;
    assign w_amt[0]   = in_amt;
    assign w_op[0]    = shift_op_t'(in_op);
    assign w_carry[0] = in_cin;
    assign w_tag[0]   = in_tag;

    // w_rdy[k] is "stage k may load"; resolved in one process so out_ready ripples straight to in_ready.
    always_comb begin
        w_rdy = '0;
        w_rdy[SHAMT_W] = out_ready;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            w_rdy[k] = !w_vld[k+1] || w_rdy[k+1];
        end
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .STAGE (k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_vld   (w_vld[k]),
            .i_rdy   (w_rdy[k+1]),
            .i_dat   (w_dat[k]),
            .i_amt   (w_amt[k]),
            .i_op    (w_op[k]),
            .i_carry (w_carry[k]),
            .i_tag   (w_tag[k]),
            .o_vld   (w_vld[k+1]),
            .o_dat   (w_dat[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_op    (w_op[k+1]),
            .o_carry (w_carry[k+1]),
            .o_tag   (w_tag[k+1])
        );
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = w_vld[SHAMT_W];
    assign out_res   = w_dat[SHAMT_W];
    assign out_cout  = w_carry[SHAMT_W];
    assign out_tag   = w_tag[SHAMT_W];
    assign out_z     = (w_dat[SHAMT_W] == '0);
    assign out_n     = w_dat[SHAMT_W][WIDTH-1];

    assign w_unused  = ^{w_amt[SHAMT_W], w_op[SHAMT_W]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe at WIDTH=8 (three-stage pipeline).
module tb_barrel_shift_pipe;
    import barrel_pkg::*;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [SW-1:0] in_amt;
    logic [2:0]    in_op;
    logic          in_cin;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic          out_cout;
    logic          out_z;
    logic          out_n;
    logic [TW-1:0] out_tag;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    barrel_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_cout  (out_cout),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [SW-1:0] amt;
        logic          cin;
        logic [W-1:0]  res;
        logic          cout;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [SW-1:0] amt,
                         input logic cin, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_amt   = amt;
        in_cin   = cin;
        in_tag   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int            lat;
        logic [W-1:0]  a8;

        vecs[0]  = '{OP_LSR, 8'hB4, 3'd3, 1'b0, 8'h16, 1'b1};
        vecs[1]  = '{OP_ASR, 8'h81, 3'd7, 1'b0, 8'hFF, 1'b0};
        vecs[2]  = '{OP_ROR, 8'h81, 3'd1, 1'b0, 8'hC0, 1'b1};
        vecs[3]  = '{OP_LSL, 8'h81, 3'd1, 1'b0, 8'h02, 1'b1};
        vecs[4]  = '{OP_ROL, 8'h81, 3'd4, 1'b0, 8'h18, 1'b0};
        vecs[5]  = '{OP_RRX, 8'h01, 3'd5, 1'b1, 8'h80, 1'b1};
        vecs[6]  = '{OP_LSL, 8'h00, 3'd0, 1'b1, 8'h00, 1'b1};
        vecs[7]  = '{3'b110, 8'h5A, 3'd3, 1'b1, 8'h5A, 1'b1};
        vecs[8]  = '{OP_ROR, 8'h01, 3'd7, 1'b1, 8'h02, 1'b0};
        vecs[9]  = '{OP_LSR, 8'hF0, 3'd0, 1'b0, 8'hF0, 1'b0};
        vecs[10] = '{OP_ASR, 8'h7F, 3'd7, 1'b0, 8'h00, 1'b1};
        vecs[11] = '{OP_LSL, 8'h01, 3'd7, 1'b1, 8'h80, 1'b0};
        vecs[12] = '{OP_ROL, 8'h81, 3'd1, 1'b0, 8'h03, 1'b1};
        vecs[13] = '{OP_RRX, 8'h02, 3'd3, 1'b0, 8'h01, 1'b0};

        rst_n = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_amt = '0; in_cin = 1'b0; in_tag = '0;
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_res",   out_res,   0);
        check("rst_cout",  out_cout,  0);
        check("rst_z",     out_z,     1);
        check("rst_n",     out_n,     0);
        check("rst_tag",   out_tag,   0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid",    out_valid, 0);

        // Single operations, one at a time, with latency measured from the presenting cycle.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].amt, vecs[i].cin, TW'(i));
            check("vec_in_ready", in_ready, 1);
            lat = 0;
            do begin
                tick();
                in_valid = 1'b0;
                lat++;
            end while (!out_valid && lat < 8);
            check($sformatf("vec%0d_latency", i), lat, SW);
            check($sformatf("vec%0d_res", i),  out_res,  vecs[i].res);
            check($sformatf("vec%0d_cout", i), out_cout, vecs[i].cout);
            check($sformatf("vec%0d_z", i),    out_z,    vecs[i].res == 0);
            check($sformatf("vec%0d_n", i),    out_n,    vecs[i].res[W-1]);
            check($sformatf("vec%0d_tag", i),  out_tag,  i[TW-1:0]);
        end
        tick();
        check("drained_valid", out_valid, 0);

        // Streaming: ten back-to-back LSL #1 ops, results expected one per cycle.
        for (int c = 0; c < 15; c++) begin
            check($sformatf("stream_vld_c%0d", c), out_valid, (c >= SW && c < SW + 10));
            if (c >= SW && c < SW + 10) begin
                a8 = 8'((c - SW) * 29);
                check($sformatf("stream_tag_c%0d", c),  out_tag,  (c - SW));
                check($sformatf("stream_res_c%0d", c),  out_res,  {a8[W-2:0], 1'b0});
                check($sformatf("stream_cout_c%0d", c), out_cout, a8[W-1]);
            end
            if (c < 10) begin
                check($sformatf("stream_in_ready_c%0d", c), in_ready, 1);
                drive(OP_LSL, 8'(c * 29), 3'd1, 1'b0, TW'(c));
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end

        // Back-pressure: fill three stages, stall five cycles, then drain.
        out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            drive(OP_LSR, 8'(t * 17), 3'd0, 1'b0, TW'(t));
            tick();
        end
        in_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check($sformatf("stall_in_ready_%0d", s), in_ready, 0);
            check($sformatf("stall_valid_%0d", s),    out_valid, 1);
            check($sformatf("stall_tag_%0d", s),      out_tag, 1);
            check($sformatf("stall_res_%0d", s),      out_res, 8'h11);
            tick();
        end
        out_ready = 1'b1;
        check("drain_tag1", out_tag, 1);
        tick();
        check("drain_valid2", out_valid, 1);
        check("drain_tag2",   out_tag, 2);
        check("drain_res2",   out_res, 8'h22);
        tick();
        check("drain_valid3", out_valid, 1);
        check("drain_tag3",   out_tag, 3);
        check("drain_res3",   out_res, 8'h33);
        tick();
        check("drain_empty", out_valid, 0);

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int t = 5; t <= 7; t++) begin
            drive(OP_ROR, 8'hF0, 3'd2, 1'b0, TW'(t));
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_full", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid",    out_valid, 0);
        check("mid_rst_z",        out_z, 1);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_res",      out_res, 0);
        check("mid_rst_tag",      out_tag, 0);
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            tick();
            check($sformatf("no_stale_%0d", s), out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
